// File: rtl/stream_scan_if.sv
// Handshake/bus bundle between the host side and the serial scan sequencer.
// The host (master) presents a word and pattern; the sequencer (slave) streams bits back.
interface stream_scan_if #(
    parameter int WORD_W = 32,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 6
);
    logic              start;
    logic              abort;
    logic              overlap;
    logic [WORD_W-1:0] data_in;
    logic [PAT_W-1:0]  pattern;
    logic              busy;
    logic              bit_out;
    logic              bit_valid;
    logic              done;
    logic [CNT_W-1:0]  match_count;

    modport master (
        output start, abort, overlap, data_in, pattern,
        input  busy, bit_out, bit_valid, done, match_count
    );

    modport slave (
        input  start, abort, overlap, data_in, pattern,
        output busy, bit_out, bit_valid, done, match_count
    );
endinterface

// File: rtl/stream_scan_ctrl.sv
// Serial scan sequencer: shifts a captured word out MSB-first and counts
// occurrences of a captured PAT_W-bit pattern, with optional overlap.
module stream_scan_ctrl #(
    parameter int WORD_W = 32,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 6
) (
    input logic         clk,
    input logic         reset,
    stream_scan_if.slave bus
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam int BW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  hist_nxt;
    logic [FW-1:0]     fill_nxt;
    logic              hit;

    assign hist_nxt = {hist_q[PAT_W-2:0], shreg_q[WORD_W-1]};
    assign fill_nxt = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
    assign hit      = (hist_nxt == pat_q) && (fill_nxt == FW'(PAT_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // abort wins over the final bit, so the last SHIFT cycle can still skip DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT: begin
                if (bus.abort)                            state_d = IDLE;
                else if (bitcnt_q == BW'(WORD_W - 1))     state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_q == SHIFT);
        bus.bit_valid   = (state_q == SHIFT);
        bus.bit_out     = (state_q == SHIFT) & shreg_q[WORD_W-1];
        bus.done        = (state_q == DONE);
        bus.match_count = cnt_q;
    end

    // The bit of an aborted cycle is still consumed and may still score a match.
    always_comb begin
        shreg_d  = shreg_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d  = bus.data_in;
                    pat_d    = bus.pattern;
                    ovl_d    = bus.overlap;
                    hist_d   = '0;
                    fill_d   = '0;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                shreg_d  = shreg_q << 1;
                hist_d   = hist_nxt;
                fill_d   = (hit && !ovl_q) ? '0 : fill_nxt;
                bitcnt_d = bitcnt_q + 1'b1;
                if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q  <= '0;
            pat_q    <= '0;
            ovl_q    <= 1'b0;
            hist_q   <= '0;
            fill_q   <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            shreg_q  <= shreg_d;
            pat_q    <= pat_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_scan_ctrl.sv
// Bench for stream_scan_ctrl: vector table plus abort/restart/reset sequences,
// with done-time count checks through per-DUT scoreboards (CNT_W=6 and CNT_W=4).
module tb_stream_scan_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stream_scan_if #(.WORD_W(32), .PAT_W(3), .CNT_W(6)) b6 ();
    stream_scan_if #(.WORD_W(32), .PAT_W(3), .CNT_W(4)) b4 ();

    stream_scan_ctrl #(.WORD_W(32), .PAT_W(3), .CNT_W(6)) dut6 (.clk(clk), .reset(reset), .bus(b6));
    stream_scan_ctrl #(.WORD_W(32), .PAT_W(3), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    assign b4.start   = b6.start;
    assign b4.abort   = b6.abort;
    assign b4.overlap = b6.overlap;
    assign b4.data_in = b6.data_in;
    assign b4.pattern = b6.pattern;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  p;
        logic        o;
        int          exp;
        int          mid_start;
        bit          ab_at_start;
    } vec_t;

    vec_t tbl[$];
    int   q6[$];
    int   q4[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sliding-window reference: count windows equal to p; without overlap a
    // window may only start once the previous match's bits are used up.
    function automatic int model(input logic [31:0] d, input logic [2:0] p, input logic o);
        int n = 0;
        int next_ok = 0;
        logic [31:0] w;
        for (int i = 0; i <= 29; i++) begin
            w = d << i;
            if (w[31:29] == p && (o || i >= next_ok)) begin
                n++;
                next_ok = i + 3;
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (reset && b6.done) begin
            if (q6.size() == 0) chk("unexpected_done_w6", 1, 0);
            else chk("count_w6", b6.match_count, q6.pop_front());
        end
        if (reset && b4.done) begin
            if (q4.size() == 0) chk("unexpected_done_w4", 1, 0);
            else chk("count_w4", b4.match_count, q4.pop_front());
        end
    end

    task automatic do_scan(input vec_t v, input bit chk_bits);
        q6.push_back(v.exp);
        q4.push_back(v.exp > 15 ? 15 : v.exp);
        b6.data_in = v.d;
        b6.pattern = v.p;
        b6.overlap = v.o;
        b6.abort   = v.ab_at_start;
        b6.start   = 1'b1;
        tick();
        b6.start   = 1'b0;
        b6.abort   = 1'b0;
        b6.data_in = $urandom;
        b6.pattern = 3'($urandom);
        b6.overlap = 1'($urandom);
        for (int i = 0; i < 32; i++) begin
            if (chk_bits) begin
                chk("bit_out", b6.bit_out, v.d[31-i]);
                chk("bit_valid", b6.bit_valid, 1);
            end
            if (i == 0 || i == 31) chk("busy_in_shift", b6.busy, 1);
            b6.start = (i == v.mid_start);
            tick();
            b6.start = 1'b0;
        end
        chk("done_after_E0_32", b6.done, 1);
        chk("busy_in_done", b6.busy, 0);
        tick();
        chk("done_one_cycle", b6.done, 0);
        chk("idle_after_done", b6.busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, b6.busy, 0);
        chk({tag, "_bit_out"}, b6.bit_out, 0);
        chk({tag, "_bit_valid"}, b6.bit_valid, 0);
        chk({tag, "_done"}, b6.done, 0);
        chk({tag, "_count"}, b6.match_count, 0);
        chk({tag, "_count_w4"}, b4.match_count, 0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] rd;
        logic [2:0]  rp;
        logic        ro;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        b6.start = 1'b0;
        b6.abort = 1'b0;
        b6.overlap = 1'b0;
        b6.data_in = '0;
        b6.pattern = '0;

        tbl.push_back('{32'hC000_0000, 3'b110, 1'b1, 1,  -1, 1'b0});
        tbl.push_back('{32'hA800_0000, 3'b101, 1'b1, 2,  -1, 1'b0});
        tbl.push_back('{32'hA800_0000, 3'b101, 1'b0, 1,  -1, 1'b0});
        tbl.push_back('{32'hFFFF_FFFF, 3'b111, 1'b1, 30, -1, 1'b0});
        tbl.push_back('{32'hFFFF_FFFF, 3'b111, 1'b0, 10, -1, 1'b0});
        tbl.push_back('{32'h0000_0000, 3'b000, 1'b0, 10, -1, 1'b0});
        tbl.push_back('{32'hAAAA_AAAA, 3'b010, 1'b1, 15, -1, 1'b0});
        tbl.push_back('{32'hAAAA_AAAA, 3'b010, 1'b0, 8,  -1, 1'b0});
        tbl.push_back('{32'h0000_0006, 3'b110, 1'b1, 1,  -1, 1'b0});
        tbl.push_back('{32'h5555_5555, 3'b111, 1'b1, 0,  -1, 1'b0});
        tbl.push_back('{32'hC000_0000, 3'b110, 1'b1, 1,  15, 1'b0});
        tbl.push_back('{32'hC000_0000, 3'b110, 1'b1, 1,  -1, 1'b1});
        for (int k = 0; k < 6; k++) begin
            rd = $urandom;
            rp = 3'($urandom);
            ro = 1'($urandom);
            tbl.push_back('{rd, rp, ro, model(rd, rp, ro), -1, 1'b0});
        end

        #12;
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        chk_all_zero("post_reset_idle");

        foreach (tbl[k]) do_scan(tbl[k], 1'b1);

        // abort after 10 bits of case 1: partial count held, no done
        v = tbl[0];
        b6.data_in = v.d; b6.pattern = v.p; b6.overlap = v.o;
        b6.start = 1'b1;
        tick();
        b6.start = 1'b0;
        repeat (10) tick();
        b6.abort = 1'b1;
        tick();
        b6.abort = 1'b0;
        chk("abort_busy", b6.busy, 0);
        chk("abort_count_held", b6.match_count, 1);
        repeat (40) begin
            tick();
            chk("abort_no_done", b6.done, 0);
        end
        chk("abort_count_still_held", b6.match_count, 1);
        b6.abort = 1'b1;
        tick();
        b6.abort = 1'b0;
        chk("abort_idle_noeffect", b6.match_count, 1);
        b6.data_in = 32'h0; b6.pattern = 3'b111; b6.overlap = 1'b1;
        b6.start = 1'b1;
        tick();
        b6.start = 1'b0;
        chk("restart_clears_count", b6.match_count, 0);
        repeat (31) tick();
        q6.push_back(0);
        q4.push_back(0);
        tick();
        tick();

        // abort on the very last bit: final match counted, done suppressed
        b6.data_in = 32'h0000_0006; b6.pattern = 3'b110; b6.overlap = 1'b0;
        b6.start = 1'b1;
        tick();
        b6.start = 1'b0;
        repeat (31) tick();
        b6.abort = 1'b1;
        tick();
        b6.abort = 1'b0;
        chk("lastbit_abort_done", b6.done, 0);
        chk("lastbit_abort_busy", b6.busy, 0);
        chk("lastbit_abort_count", b6.match_count, 1);
        tick();
        chk("lastbit_abort_done_later", b6.done, 0);

        // asynchronous reset in the middle of a scan
        b6.data_in = 32'hFFFF_FFFF; b6.pattern = 3'b111; b6.overlap = 1'b1;
        b6.start = 1'b1;
        tick();
        b6.start = 1'b0;
        repeat (8) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midscan_reset");
        tick();
        reset = 1'b1;
        tick();
        chk_all_zero("after_reset_release");
        do_scan(tbl[0], 1'b1);

        repeat (3) tick();
        chk("scoreboard_w6_empty", q6.size(), 0);
        chk("scoreboard_w4_empty", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
